// File: rtl/fft_pkg.sv
// Shared FFT package: complex sample type, frame type and frame geometry.
//   complex : packed {re, im}, each signed 16-bit
//   frame_t : FFT_N complex samples, element i = i-th sample of the frame
//   FFT_N   : points per frame
//   IDX_W   : width of a sample index within a frame
package fft_pkg;
    localparam int FFT_N = 8;
    localparam int IDX_W = $clog2(FFT_N);

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex;

    typedef complex [FFT_N-1:0] frame_t;
endpackage

// File: rtl/fft8_frame_loader_if.sv
// Sample-stream interface into the frame loader (valid/ready handshake).
//   s_valid : source has a sample
//   s_ready : loader can accept a sample this cycle
//   s_data  : complex sample {re, im}
//   s_last  : final sample of a (possibly short) frame
// Modports: master = sample source, slave = loader.
interface fft8_frame_loader_if;
    import fft_pkg::*;

    logic   s_valid;
    logic   s_ready;
    complex s_data;
    logic   s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/fft8_frame_bank.sv
// One FFT_N-entry complex register bank with a parallel read port.
//   clk     : clock, rising edge
//   rst     : synchronous active-low reset, clears all entries
//   i_we    : write i_data into entry i_idx
//   i_idx   : write index
//   i_data  : sample to write
//   i_pad   : with i_we, zero every entry above i_idx (short-frame close)
//   o_frame : all entries in parallel
module fft8_frame_bank
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  complex           i_data,
    input  logic             i_pad,
    output frame_t           o_frame
);

    frame_t r_mem;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem <= '0;
        end else if (i_we) begin
            for (int unsigned i = 0; i < FFT_N; i++) begin
                if (IDX_W'(i) == i_idx) begin
                    r_mem[i] <= i_data;
                end else if (i_pad && (IDX_W'(i) > i_idx)) begin
                    r_mem[i] <= '0;
                end
            end
        end
    end

    assign o_frame = r_mem;

endmodule

// File: rtl/fft8_frame_loader.sv
// Serial-to-parallel front end for FFT8. Samples arriving over a valid/ready
// stream are collected into two ping-pong banks; each closed frame is issued
// in FIFO order as a one-cycle fft_valid pulse with the whole frame on fft_din.
// Parameters:
//   ISSUE_GAP : minimum cycles between fft_valid pulses (1 = back-to-back)
//   CNT_W     : width of frame_cnt
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   flush     : discard the partially filled write bank (wins over an accept)
//   s_if      : sample stream (slave side)
//   fft_din   : last issued frame, element i = i-th accepted sample
//   fft_valid : one-cycle issue pulse
//   frame_err : one-cycle pulse after a frame is closed short by s_last
//   frame_cnt : issued frames, wraps modulo 2^CNT_W
module fft8_frame_loader
    import fft_pkg::*;
#(
    parameter int ISSUE_GAP = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    fft8_frame_loader_if.slave   s_if,
    output frame_t               fft_din,
    output logic                 fft_valid,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [1:0]       r_full;
    logic [IDX_W-1:0] r_wr_idx;
    logic [GAP_W-1:0] r_gap;
    frame_t           r_din;
    logic             r_valid;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_ready;
    logic             w_acc;
    logic             w_close;
    logic             w_short;
    logic             w_issue;
    logic [1:0]       w_full_nxt;
    frame_t           w_frame0;
    frame_t           w_frame1;
    frame_t           w_rd_frame;

    // Ready is held low during reset regardless of stored state.
    assign w_ready = rst & ~r_full[r_wr_bank];
    // A flush in the same cycle drops the offered sample.
    assign w_acc   = s_if.s_valid & w_ready & ~flush;
    assign w_close = w_acc & ((r_wr_idx == IDX_W'(FFT_N - 1)) | s_if.s_last);
    assign w_short = w_acc & s_if.s_last & (r_wr_idx != IDX_W'(FFT_N - 1));
    assign w_issue = r_full[r_rd_bank] & (r_gap == '0);

    assign w_rd_frame = r_rd_bank ? w_frame1 : w_frame0;

    // Close and issue never target the same bank: a full write bank blocks
    // accepts, so both updates can be applied independently.
    always_comb begin
        w_full_nxt = r_full;
        if (w_issue) w_full_nxt[r_rd_bank] = 1'b0;
        if (w_close) w_full_nxt[r_wr_bank] = 1'b1;
    end

    fft8_frame_bank u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_acc & ~r_wr_bank),
        .i_idx   (r_wr_idx),
        .i_data  (s_if.s_data),
        .i_pad   (s_if.s_last),
        .o_frame (w_frame0)
    );

    fft8_frame_bank u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_acc & r_wr_bank),
        .i_idx   (r_wr_idx),
        .i_data  (s_if.s_data),
        .i_pad   (s_if.s_last),
        .o_frame (w_frame1)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_full    <= '0;
            r_wr_idx  <= '0;
            r_gap     <= '0;
            r_din     <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_valid <= w_issue;
            r_err   <= w_short;
            r_full  <= w_full_nxt;

            if (w_issue) begin
                r_din     <= w_rd_frame;
                r_rd_bank <= ~r_rd_bank;
                r_cnt     <= r_cnt + CNT_W'(1);
                r_gap     <= GAP_W'(ISSUE_GAP - 1);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end

            if (flush) begin
                r_wr_idx <= '0;
            end else if (w_close) begin
                r_wr_idx  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else if (w_acc) begin
                r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
        end
    end

    assign s_if.s_ready = w_ready;
    assign fft_din      = r_din;
    assign fft_valid    = r_valid;
    assign frame_err    = r_err;
    assign frame_cnt    = r_cnt;

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Bench for fft8_frame_loader: one instance with ISSUE_GAP=1 (a) and one with
// ISSUE_GAP=12 (b). Expected frames are pushed to per-instance queues as
// samples are accepted and popped when fft_valid is observed.
module tb_fft8_frame_loader;
    import fft_pkg::*;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush_a, flush_b;

    fft8_frame_loader_if sa ();
    fft8_frame_loader_if sb ();

    frame_t             din_a, din_b;
    logic               valid_a, valid_b, err_a, err_b;
    logic [CNT_W-1:0]   cnt_a, cnt_b;

    fft8_frame_loader #(.ISSUE_GAP(1), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .s_if(sa),
        .fft_din(din_a), .fft_valid(valid_a), .frame_err(err_a), .frame_cnt(cnt_a)
    );

    fft8_frame_loader #(.ISSUE_GAP(12), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .s_if(sb),
        .fft_din(din_b), .fft_valid(valid_b), .frame_err(err_b), .frame_cnt(cnt_b)
    );

    typedef struct {
        frame_t           f;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t   q_a[$];
    exp_t   q_b[$];
    exp_t   ea, eb;
    int     n_chk = 0;
    int     n_err = 0;
    int     cyc_n = 0;
    int     pulses_a[$];
    int     pulses_b[$];
    int     errp_a = 0;
    int     errp_b = 0;
    frame_t part[2];
    int     idx[2];
    int     closed[2];

    always @(posedge clk) cyc_n++;

    // Scoreboard: every fft_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (valid_a === 1'b1) begin
                pulses_a.push_back(cyc_n);
                n_chk++;
                if (q_a.size() == 0) begin
                    n_err++;
                    $display("FAIL pulse_a_unexpected: fft_valid=1 at cycle %0d, required no pulse", cyc_n);
                end else begin
                    ea = q_a.pop_front();
                    if (din_a !== ea.f) begin
                        n_err++;
                        $display("FAIL frame_a_data: got %h required %h", din_a, ea.f);
                    end
                    n_chk++;
                    if (cnt_a !== ea.cnt) begin
                        n_err++;
                        $display("FAIL frame_a_cnt: got %0d required %0d", cnt_a, ea.cnt);
                    end
                end
            end
            if (valid_b === 1'b1) begin
                pulses_b.push_back(cyc_n);
                n_chk++;
                if (q_b.size() == 0) begin
                    n_err++;
                    $display("FAIL pulse_b_unexpected: fft_valid=1 at cycle %0d, required no pulse", cyc_n);
                end else begin
                    eb = q_b.pop_front();
                    if (din_b !== eb.f) begin
                        n_err++;
                        $display("FAIL frame_b_data: got %h required %h", din_b, eb.f);
                    end
                    n_chk++;
                    if (cnt_b !== eb.cnt) begin
                        n_err++;
                        $display("FAIL frame_b_cnt: got %0d required %0d", cnt_b, eb.cnt);
                    end
                end
            end
            if (err_a === 1'b1) errp_a++;
            if (err_b === 1'b1) errp_b++;
        end
    end

    function automatic complex mk(input int r, input int i);
        complex c;
        c.re = 16'(r);
        c.im = 16'(i);
        return c;
    endfunction

    // One stimulus cycle on instance w; the model tracks what the loader keeps.
    task automatic cyc(input int w, input logic v, input complex d, input logic l,
                       input logic fl, output logic acc);
        logic rdy;
        exp_t ex;
        @(negedge clk);
        if (w == 0) begin
            sa.s_valid = v; sa.s_data = d; sa.s_last = l; flush_a = fl;
        end else begin
            sb.s_valid = v; sb.s_data = d; sb.s_last = l; flush_b = fl;
        end
        #1;
        rdy = (w == 0) ? sa.s_ready : sb.s_ready;
        acc = v & rdy & ~fl;
        if (fl) begin
            idx[w]  = 0;
            part[w] = '0;
        end else if (acc) begin
            part[w][idx[w]] = d;
            if (idx[w] == FFT_N - 1 || l) begin
                closed[w]++;
                ex.f   = part[w];
                ex.cnt = CNT_W'(closed[w]);
                if (w == 0) q_a.push_back(ex);
                else        q_b.push_back(ex);
                part[w] = '0;
                idx[w]  = 0;
            end else begin
                idx[w]++;
            end
        end
    endtask

    task automatic idle(input int w, input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(w, 1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic drain(input int w, input int bound);
        int n = 0;
        while (((w == 0) ? q_a.size() : q_b.size()) != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        #1;
        n_chk++;
        if (((w == 0) ? q_a.size() : q_b.size()) != 0) begin
            n_err++;
            $display("FAIL drain_timeout_%0d: %0d frames still pending, required 0",
                     w, (w == 0) ? q_a.size() : q_b.size());
        end
    endtask

    task automatic clear_model();
        q_a.delete(); q_b.delete();
        for (int w = 0; w < 2; w++) begin
            part[w] = '0; idx[w] = 0; closed[w] = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sa.s_valid = 1'b0; sa.s_data = '0; sa.s_last = 1'b0; flush_a = 1'b0;
        sb.s_valid = 1'b0; sb.s_data = '0; sb.s_last = 1'b0; flush_b = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        n_chk++; if (sa.s_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_a: got %b required 0", sa.s_ready); end
        n_chk++; if (sb.s_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_b: got %b required 0", sb.s_ready); end
        n_chk++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b required 0", valid_a); end
        n_chk++; if (din_a !== '0) begin n_err++; $display("FAIL rst_din: got %h required 0", din_a); end
        n_chk++; if (cnt_a !== '0 || cnt_b !== '0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d required 0/0", cnt_a, cnt_b); end
        n_chk++; if (err_a !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b required 0", err_a); end
        rst = 1'b1;
        #1;
        n_chk++; if (sa.s_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b required 1", sa.s_ready); end
    endtask

    task automatic test_single_frame();
        int re_v[8] = '{8528, -4736, 1327, 5274, -195, 4419, 6660, 1914};
        int im_v[8] = '{317, -8800, -4191, 4635, -139, -240, -7263, 9072};
        int   n_acc = 0;
        int   e0 = errp_a;
        logic acc;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1'b1, mk(re_v[i], im_v[i]), 1'b0, 1'b0, acc);
            if (acc) n_acc++;
        end
        cyc(0, 1'b0, '0, 1'b0, 1'b0, acc);
        n_chk++; if (n_acc != 8) begin n_err++; $display("FAIL single_accepts: got %0d required 8", n_acc); end
        n_chk++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL single_early: fft_valid=%b required 0", valid_a); end
        cyc(0, 1'b0, '0, 1'b0, 1'b0, acc);
        n_chk++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL single_latency: fft_valid=%b required 1", valid_a); end
        n_chk++; if (din_a[0] !== mk(8528, 317)) begin n_err++; $display("FAIL single_din0: got %h required %h", din_a[0], mk(8528, 317)); end
        n_chk++; if (din_a[7] !== mk(1914, 9072)) begin n_err++; $display("FAIL single_din7: got %h required %h", din_a[7], mk(1914, 9072)); end
        n_chk++; if (cnt_a !== 16'd1) begin n_err++; $display("FAIL single_cnt: got %0d required 1", cnt_a); end
        idle(0, 3);
        n_chk++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL single_pulse_width: fft_valid=%b required 0", valid_a); end
        n_chk++; if (din_a[0] !== mk(8528, 317)) begin n_err++; $display("FAIL single_hold: got %h required %h", din_a[0], mk(8528, 317)); end
        n_chk++; if (errp_a != e0) begin n_err++; $display("FAIL single_no_err: frame_err pulses %0d required 0", errp_a - e0); end
    endtask

    task automatic test_back_to_back();
        int   drops = 0;
        logic acc;
        pulses_a.delete();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 8; i++) begin
                cyc(0, 1'b1, mk(f * 1000 + i * 7 - 1500, -(f * 300) + i * 11), 1'b0, 1'b0, acc);
                if (!acc) drops++;
            end
        cyc(0, 1'b0, '0, 1'b0, 1'b0, acc);
        drain(0, 40);
        n_chk++; if (drops != 0) begin n_err++; $display("FAIL b2b_ready: dropped %0d cycles required 0", drops); end
        n_chk++;
        if (pulses_a.size() != 4) begin
            n_err++; $display("FAIL b2b_pulses: got %0d required 4", pulses_a.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_chk++;
                if (pulses_a[i] - pulses_a[i-1] != 8) begin
                    n_err++; $display("FAIL b2b_spacing: got %0d required 8", pulses_a[i] - pulses_a[i-1]);
                end
            end
        end
        n_chk++; if (cnt_a !== 16'd5) begin n_err++; $display("FAIL b2b_cnt: got %0d required 5", cnt_a); end
    endtask

    task automatic test_issue_gap();
        int   sent = 0;
        int   drops = 0;
        int   n = 0;
        logic acc;
        pulses_b.delete();
        while (sent < 40 && n < 400) begin
            cyc(1, 1'b1, mk(sent * 13 - 200, 500 - sent * 17), 1'b0, 1'b0, acc);
            if (acc) sent++;
            else     drops++;
            n++;
        end
        cyc(1, 1'b0, '0, 1'b0, 1'b0, acc);
        n_chk++; if (sent != 40) begin n_err++; $display("FAIL gap_recover: sent %0d required 40", sent); end
        n_chk++; if (drops == 0) begin n_err++; $display("FAIL gap_backpressure: ready drops %0d required >0", drops); end
        drain(1, 200);
        n_chk++;
        if (pulses_b.size() != 5) begin
            n_err++; $display("FAIL gap_pulses: got %0d required 5", pulses_b.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                n_chk++;
                if (pulses_b[i] - pulses_b[i-1] < 12) begin
                    n_err++; $display("FAIL gap_spacing: got %0d required >=12", pulses_b[i] - pulses_b[i-1]);
                end
            end
        end
    endtask

    task automatic test_short_frame();
        int   e0 = errp_a;
        logic acc;
        for (int i = 0; i < 4; i++) cyc(0, 1'b1, mk(i + 10, i - 10), 1'b0, 1'b0, acc);
        cyc(0, 1'b1, mk(100, -100), 1'b1, 1'b0, acc);
        cyc(0, 1'b0, '0, 1'b0, 1'b0, acc);
        n_chk++; if (err_a !== 1'b1) begin n_err++; $display("FAIL short_err_pulse: got %b required 1", err_a); end
        cyc(0, 1'b0, '0, 1'b0, 1'b0, acc);
        n_chk++; if (err_a !== 1'b0) begin n_err++; $display("FAIL short_err_width: got %b required 0", err_a); end
        n_chk++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL short_issue: fft_valid=%b required 1", valid_a); end
        n_chk++; if (din_a[4] !== mk(100, -100)) begin n_err++; $display("FAIL short_din4: got %h required %h", din_a[4], mk(100, -100)); end
        for (int i = 5; i < 8; i++) begin
            n_chk++; if (din_a[i] !== '0) begin n_err++; $display("FAIL short_pad%0d: got %h required 0", i, din_a[i]); end
        end
        // s_last on the eighth sample is a normal close.
        for (int i = 0; i < 8; i++) cyc(0, 1'b1, mk(-i, i * 3), (i == 7), 1'b0, acc);
        idle(0, 3);
        drain(0, 20);
        n_chk++; if (errp_a - e0 != 1) begin n_err++; $display("FAIL short_err_count: got %0d required 1", errp_a - e0); end
    endtask

    task automatic test_flush();
        int   e0 = errp_a;
        logic acc;
        for (int i = 0; i < 3; i++) cyc(0, 1'b1, mk(50 + i, -50 - i), 1'b0, 1'b0, acc);
        cyc(0, 1'b1, mk(99, -99), 1'b0, 1'b1, acc);
        cyc(0, 1'b0, '0, 1'b0, 1'b0, acc);
        for (int k = 1; k <= 8; k++) cyc(0, 1'b1, mk(k, -k), 1'b0, 1'b0, acc);
        idle(0, 2);
        drain(0, 20);
        n_chk++; if (din_a[0] !== mk(1, -1)) begin n_err++; $display("FAIL flush_din0: got %h required %h", din_a[0], mk(1, -1)); end
        n_chk++; if (din_a[7] !== mk(8, -8)) begin n_err++; $display("FAIL flush_din7: got %h required %h", din_a[7], mk(8, -8)); end
        n_chk++; if (errp_a != e0) begin n_err++; $display("FAIL flush_no_err: got %0d required 0", errp_a - e0); end
    endtask

    task automatic test_reset_midframe();
        logic acc;
        for (int i = 0; i < 16; i++) cyc(1, 1'b1, mk(i + 300, -i - 300), 1'b0, 1'b0, acc);
        for (int i = 0; i < 2; i++)  cyc(1, 1'b1, mk(i + 700, i), 1'b0, 1'b0, acc);
        cyc(0, 1'b1, mk(1, 2), 1'b0, 1'b0, acc);
        @(negedge clk);
        rst = 1'b0;
        sa.s_valid = 1'b0; sb.s_valid = 1'b0;
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++; if (din_a !== '0 || din_b !== '0) begin n_err++; $display("FAIL midrst_din: got %h / %h required 0", din_a[0], din_b[0]); end
        n_chk++; if (cnt_a !== '0 || cnt_b !== '0) begin n_err++; $display("FAIL midrst_cnt: got %0d/%0d required 0/0", cnt_a, cnt_b); end
        pulses_a.delete(); pulses_b.delete();
        idle(1, 20);
        n_chk++; if (pulses_a.size() + pulses_b.size() != 0) begin n_err++; $display("FAIL midrst_stale_pulse: got %0d pulses required 0", pulses_a.size() + pulses_b.size()); end
        for (int i = 0; i < 8; i++) cyc(1, 1'b1, mk(i * 5, -i * 9), 1'b0, 1'b0, acc);
        cyc(1, 1'b0, '0, 1'b0, 1'b0, acc);
        drain(1, 20);
        n_chk++; if (cnt_b !== 16'd1) begin n_err++; $display("FAIL midrst_next_cnt: got %0d required 1", cnt_b); end
        n_chk++; if (pulses_b.size() != 1) begin n_err++; $display("FAIL midrst_next_pulse: got %0d required 1", pulses_b.size()); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_issue_gap();
        test_short_frame();
        test_flush();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
